// File: rtl/imm_encoder_pkg.sv
// Shared opcodes, error codes and helpers for the immediate encoder.
// The err_cnt feature is gated by the IMM_ENC_ERR_CNT_EN macro in imm_encoder.
package imm_encoder_pkg;

  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_U  = 7'b0110111;
  localparam logic [6:0] OP_J  = 7'b1101111;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_OP    = 2'd3
  } err_code_t;

  // True when v equals the sign extension of its low 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_field_pack.sv
// Combinational field packer and encodability check for one request.
module imm_field_pack
  import imm_encoder_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output err_code_t   err_code
);

  logic [31:0] raw;
  logic        op_ok;
  logic        misaligned;
  logic        in_range;

  always_comb begin
    raw        = '0;
    op_ok      = 1'b1;
    misaligned = 1'b0;
    in_range   = 1'b1;
    case (op)
      OP_I, OP_LW: begin
        raw      = {imm[11:0], rs1, funct3, rd, op};
        in_range = fits_signed(imm, 12);
      end
      OP_S: begin
        raw      = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        in_range = fits_signed(imm, 12);
      end
      OP_B: begin
        raw        = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        in_range   = fits_signed(imm, 13);
        misaligned = imm[0];
      end
      OP_U: begin
        raw      = {imm[31:12], rd, op};
        in_range = (imm[11:0] == 12'h000);
      end
      OP_J: begin
        raw        = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        in_range   = fits_signed(imm, 21);
        misaligned = imm[0];
      end
      default: op_ok = 1'b0;
    endcase
  end

  always_comb begin
    if (!op_ok)          err_code = ERR_OP;
    else if (misaligned) err_code = ERR_ALIGN;
    else if (!in_range)  err_code = ERR_RANGE;
    else                 err_code = ERR_NONE;
    word = (err_code == ERR_NONE) ? raw : NOP_INST;
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder pipeline with valid/ready on both sides.
// Define IMM_ENC_ERR_CNT_EN to build the saturating error counter behind err_cnt.
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic        out_err,
  output logic [1:0]  err_code,
  output logic [15:0] err_cnt
);

  logic        rdy_q, rdy_d;
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_inst_q, s1_inst_d;
  err_code_t   s1_err_q, s1_err_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] inst_q, inst_d;
  err_code_t   err_q, err_d;

  logic        advance;
  logic        accept;
  logic [31:0] pack_word;
  err_code_t   pack_err;

  imm_field_pack u_pack (
    .op       (op),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .imm      (imm),
    .word     (pack_word),
    .err_code (pack_err)
  );

  // rdy_q holds in_ready low until the first clock after reset release.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = rdy_q && (advance || !s1_valid_q);
  assign accept   = in_valid && in_ready;

  always_comb begin
    rdy_d       = 1'b1;
    s1_valid_d  = s1_valid_q;
    s1_inst_d   = s1_inst_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    inst_d      = inst_q;
    err_d       = err_q;
    if (advance || !s1_valid_q) s1_valid_d = accept;
    if (accept) begin
      s1_inst_d = pack_word;
      s1_err_d  = pack_err;
    end
    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        inst_d = s1_inst_q;
        err_d  = s1_err_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_inst_q   <= '0;
      s1_err_q    <= ERR_NONE;
      out_valid_q <= 1'b0;
      inst_q      <= '0;
      err_q       <= ERR_NONE;
    end else begin
      rdy_q       <= rdy_d;
      s1_valid_q  <= s1_valid_d;
      s1_inst_q   <= s1_inst_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign inst      = inst_q;
  assign err_code  = err_q;
  assign out_err   = (err_q != ERR_NONE);

`ifdef IMM_ENC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_valid_q && out_ready && out_err && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed, table-driven bench for imm_encoder plus stall and reset sequences.
module tb_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        out_err;
  logic [1:0]  err_code;
  logic [15:0] err_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  imm_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst      (inst),
    .out_err   (out_err),
    .err_code  (err_code),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    op     = v.op;
    rd     = v.rd;
    rs1    = v.rs1;
    rs2    = v.rs2;
    funct3 = v.f3;
    imm    = v.imm;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    #1;
    chk($sformatf("v%0d_in_ready", idx), {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d_lat1_valid", idx), {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_lat2_valid", idx), {31'b0, out_valid}, 32'd1);
    chk($sformatf("v%0d_inst", idx), inst, v.exp_inst);
    chk($sformatf("v%0d_out_err", idx), {31'b0, out_err}, {31'b0, (v.exp_err != 2'd0)});
    chk($sformatf("v%0d_err_code", idx), {30'b0, err_code}, {30'b0, v.exp_err});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f, input logic [31:0] i,
                              input logic [31:0] ei, input logic [1:0] ee);
    vec_t v;
    v.op = o; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f; v.imm = i;
    v.exp_inst = ei; v.exp_err = ee;
    return v;
  endfunction

  vec_t stall_v[4];
  int   exp_errs;
  int   idx;
  int   got;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; imm = '0;

    vecs.push_back(mk(7'b0010011, 5'd1, 5'd0, 5'd31, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'd0));
    vecs.push_back(mk(7'b0110111, 5'd5, 5'd7, 5'd0,  3'd0, 32'h1234_5000, 32'h1234_52B7, 2'd0));
    vecs.push_back(mk(7'b0110111, 5'd5, 5'd0, 5'd0,  3'd0, 32'h1234_5001, NOP,           2'd1));
    vecs.push_back(mk(7'b1100011, 5'd0, 5'd1, 5'd2,  3'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 2'd0));
    vecs.push_back(mk(7'b1100011, 5'd0, 5'd1, 5'd2,  3'd0, 32'h0000_0003, NOP,           2'd2));
    vecs.push_back(mk(7'b1101111, 5'd1, 5'd0, 5'd0,  3'd0, 32'h0000_0800, 32'h0010_00EF, 2'd0));
    vecs.push_back(mk(7'b0010011, 5'd1, 5'd0, 5'd0,  3'd0, 32'h0000_0800, NOP,           2'd1));
    vecs.push_back(mk(7'h33,      5'd1, 5'd2, 5'd3,  3'd0, 32'h0000_0000, NOP,           2'd3));
    vecs.push_back(mk(7'b0100011, 5'd0, 5'd2, 5'd3,  3'd2, 32'hFFFF_FFF8, 32'hFE31_2C23, 2'd0));
    vecs.push_back(mk(7'b0000011, 5'd3, 5'd4, 5'd0,  3'd2, 32'h0000_07FF, 32'h7FF2_2183, 2'd0));
    vecs.push_back(mk(7'b0010011, 5'd1, 5'd0, 5'd0,  3'd0, 32'hFFFF_F800, 32'h8000_0093, 2'd0));
    vecs.push_back(mk(7'b1100011, 5'd0, 5'd1, 5'd2,  3'd0, 32'h0000_1000, NOP,           2'd1));
    vecs.push_back(mk(7'b1101111, 5'd0, 5'd0, 5'd0,  3'd0, 32'hFFF0_0000, 32'h8000_006F, 2'd0));
    vecs.push_back(mk(7'b1101111, 5'd1, 5'd0, 5'd0,  3'd0, 32'h0010_0000, NOP,           2'd1));
    vecs.push_back(mk(7'b1100011, 5'd0, 5'd1, 5'd2,  3'd0, 32'h0000_1001, NOP,           2'd2));
    vecs.push_back(mk(7'h00,      5'd0, 5'd0, 5'd0,  3'd0, 32'h0000_0001, NOP,           2'd3));

    stall_v[0] = mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h10, 32'h0100_0093, 2'd0);
    stall_v[1] = mk(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 32'h20, 32'h0200_0113, 2'd0);
    stall_v[2] = mk(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 32'h30, 32'h0300_0193, 2'd0);
    stall_v[3] = mk(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 32'h40, 32'h0400_0213, 2'd0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_err_code", {30'b0, err_code}, 32'd0);
    chk("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_early", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // Single-request vectors
    exp_errs = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
      if (vecs[i].exp_err != 2'd0) exp_errs++;
    end
    @(negedge clk);
`ifdef IMM_ENC_ERR_CNT_EN
    chk("vec_err_cnt", {16'b0, err_cnt}, exp_errs);
`else
    chk("vec_err_cnt", {16'b0, err_cnt}, 32'd0);
`endif

    // Back-to-back with output stalled for three cycles
    idx = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      logic acc;
      @(negedge clk);
      out_ready = (c >= 5);
      if (idx < 4) begin
        drive(stall_v[idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 2) chk($sformatf("stall_in_ready_c%0d", c), {31'b0, in_ready}, 32'd1);
      if (c >= 2 && c <= 4) begin
        chk($sformatf("stall_in_ready_c%0d", c), {31'b0, in_ready}, 32'd0);
        chk($sformatf("stall_hold_valid_c%0d", c), {31'b0, out_valid}, 32'd1);
        chk($sformatf("stall_hold_inst_c%0d", c), inst, stall_v[0].exp_inst);
        chk($sformatf("stall_hold_err_c%0d", c), {31'b0, out_err}, 32'd0);
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk($sformatf("stall_order_%0d", got), inst, stall_v[got].exp_inst);
        got++;
      end
      @(posedge clk);
      if (acc) idx++;
    end
    #1;
    in_valid = 1'b0;
    chk("stall_all_out", got, 32'd4);
    repeat (2) @(negedge clk);
    chk("stall_no_dup", {31'b0, out_valid}, 32'd0);

    // Error counting from a clean start
    do_reset();
    run_vec(vecs[2], 102);
    run_vec(vecs[4], 104);
    run_vec(vecs[7], 107);
    @(negedge clk);
`ifdef IMM_ENC_ERR_CNT_EN
    chk("cnt3_err_cnt", {16'b0, err_cnt}, 32'd3);
`else
    chk("cnt3_err_cnt", {16'b0, err_cnt}, 32'd0);
`endif

    // Two in flight, then reset asserted mid-cycle
    out_ready = 1'b0;
    drive(vecs[2]);
    in_valid = 1'b1;
    @(negedge clk);
    drive(vecs[4]);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("flight_valid", {31'b0, out_valid}, 32'd1);
    chk("flight_full", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_err_cnt", {16'b0, err_cnt}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("mid_rst_inst", inst, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined immediate encoder: accepts an opcode, register/funct fields and a 32-bit signed immediate, checks that the immediate is representable for the format, and emits the assembled 32-bit RV32I instruction word. It is the packing-side counterpart of the core's immediate decode path. It sits in the debug/instruction-injection path, feeding generated instructions to the fetch override mux. Two-stage pipeline with valid/ready handshakes on both sides.

## Interface
- No parameters.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept.
- op  input  7  opcode: I_type 0010011, OP_LW 0000011, S_type 0100011, B_type 1100011, U_type 0110111, J_type 1101111.
- rd, rs1, rs2  input  5 each  register fields.
- funct3  input  3  funct3 field.
- imm  input  32  byte-offset/immediate value as seen after decode.
- out_valid  output  1  instruction valid.
- out_ready  input  1  consumer accepts.
- inst  output  32  assembled instruction.
- out_err  output  1  request was not encodable.
- err_code  output  2  0 none, 1 range, 2 misaligned, 3 bad opcode.
- err_cnt  output  16  saturating error count (see Configuration).

## Operation
- Field placement (imm bits):
  - I/OP_LW: [31:20]=imm[11:0], rs1, funct3, rd.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0], rs2, rs1, funct3.
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11], rs2, rs1, funct3.
  - U: [31:12]=imm[31:12], rd.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd.
  - [6:0]=op in all cases; unused rs/funct inputs ignored.
- Range rules: I/LW/S: imm == sext(imm[11:0]). B: imm == sext(imm[12:0]). J: imm == sext(imm[20:0]). U: imm[11:0]==0.
- Alignment: B and J require imm[0]==0.
- Error priority: bad opcode > misaligned > range. U with imm[11:0]!=0 is range error.
- On any error: inst=32'h0000_0013 (NOP), out_err=1, err_code set. Requests are never dropped.
- Stage 1 registers check result and packed word; stage 2 is the output register.

## Timing
- Reset: out_valid=0, inst=0, out_err=0, err_code=0, err_cnt=0. in_ready is 1 one cycle after reset release. in_ready is 0 while rst_n is low.
- Latency 2 cycles from in_valid&&in_ready to out_valid. Throughput 1 per cycle when out_ready=1.
- Pipeline advances when !out_valid || out_ready. in_ready = advance || !s1_valid. Zero bubbles under continuous flow.
- inst/out_err/err_code stay stable while out_valid && !out_ready.
- Max 2 in flight. Order preserved.
- Reset asserted mid-operation discards all in-flight entries immediately.

## Configuration
- IMM_ENC_ERR_CNT_EN defined:
  - err_cnt increments on each output transfer with out_err=1 (out_valid && out_ready).
  - It saturates at 16'hFFFF.
- Not defined: err_cnt tied to 0 and no counter flops exist.

## Structure
- imm_encoder_pkg:
  - opcode constants.
  - err_code_t enum (ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_OP).
  - NOP constant.
- Sub-module imm_field_pack: combinational stage-1 pack and check of op, fields, imm into word, err_code.
- imm_encoder holds the pipeline registers, handshake logic and counter.

## Test plan
- I, rd=1, rs1=0, funct3=0, imm=32'hFFFF_FFFF -> inst 32'hFFF0_0093, out_err=0, 2 cycles later.
- U, rd=5, imm=32'h1234_5000 -> 32'h1234_52B7. Same with imm=32'h1234_5001 -> 32'h0000_0013, err_code=1.
- B, rs1=1, rs2=2, funct3=0, imm=32'hFFFF_FFFC -> 32'hFE20_8EE3. imm=3 -> err_code=2.
- J, rd=1, imm=32'h800 -> 32'h0010_00EF. I with imm=32'h800 -> err_code=1. op=7'h33 -> err_code=3.
- Back-to-back 4 valid requests with out_ready low for 3 cycles:
  - in_ready drops after 2 accepts.
  - Outputs are held stable while stalled.
  - All 4 emerge in order, no loss or duplication.
- With IMM_ENC_ERR_CNT_EN, 3 errored transfers -> err_cnt=3. Assert rst_n low with 2 in flight -> out_valid=0, err_cnt=0 at once.
